usb_fs_rx_phy: RTL and testbench
================================

# usb_fs_rx_phy

Full-speed USB receive front end: takes the differential line pair from the pin wrapper and produces the received packet as a byte stream. It is the receive counterpart of the pin-driver/transmit path. It sits between the pin wrapper's `usb_p_rx`/`usb_n_rx` nets and the protocol engine's packet decoder. The pin wrapper forces J on these nets while we transmit, so the block never sees its own traffic. Functions: input synchronisation, 4x-oversampled clock recovery, NRZI decoding, bit unstuffing, SYNC/EOP detection, byte assembly, and bus-reset detection.

## Interface
- `RESET_CYCLES`, 120: consecutive synchronised SE0 cycles that constitute bus reset (2.5 us at 48 MHz).
- `EOP_MAX_SE0`, 3: maximum SE0 bit-samples tolerated in an EOP before the packet is aborted.

Ports:
- `clk_48mhz` in 1: the only clock.
- `reset` in 1: asynchronous, active-low; 0 clears all state.
- `usb_p_rx` in 1: raw D+ from the pin wrapper; asynchronous to the clock.
- `usb_n_rx` in 1: raw D- from the pin wrapper.
- `line_state` out 2: synchronised state; 0=SE0, 1=J, 2=K, 3=SE1.
- `rx_active` out 1: high from `rx_pkt_start` until `rx_pkt_end`, inclusive.
- `rx_pkt_start` out 1: 1-cycle pulse when SYNC completes.
- `rx_data` out 8: received byte, LSB-first assembled; valid only with `rx_data_valid`.
- `rx_data_valid` out 1: 1-cycle pulse per byte.
- `rx_pkt_end` out 1: 1-cycle pulse at end of packet.
- `rx_pkt_err` out 1: qualifies `rx_pkt_end`; 1 means the packet was bad.
- `usb_reset` out 1: level, high while bus reset is detected.

## Operation
- **Synchroniser.** Two flops per line. J = (p,n)=(1,0), K = (0,1), SE0 = (0,0). SE1 is treated as a repeat of the previous sampled state.
- **Clock recovery.**
  - A 2-bit phase counter runs freely 0..3 and wraps.
  - Any change of synchronised line state loads the counter with 0.
  - A bit is sampled on the cycle the counter equals 1, i.e. roughly mid-bit.
- **NRZI.** Decoded bit is 1 if the sampled J/K equals the previous sample, 0 if it differs.
- **State IDLE.** A sampled-line-state history of KJKK (the end of SYNC) causes:
  - transition to DATA;
  - `rx_pkt_start` pulses;
  - bit counter and ones counter clear.
- **State DATA.**
  - Each decoded bit increments the ones counter if 1, and clears it if 0.
  - The bit after six consecutive 1s is a stuff bit:
    - if 0, it is discarded;
    - if 1, the block goes to ERR.
  - Non-stuff bits shift into the byte register, LSB first.
  - On the 8th bit, `rx_data` is loaded and `rx_data_valid` pulses.
  - A sampled SE0 moves to EOP.
- **State EOP.**
  - Sampled J: `rx_pkt_end` pulses and the block returns to IDLE. `rx_pkt_err` = 1 if the bit count mod 8 ≠ 0 or if zero bytes were received.
  - Sampled K: abort.
  - More than `EOP_MAX_SE0` SE0 samples: abort.
- **State ERR.** No further `rx_data_valid`. On the first sampled J after SE0, `rx_pkt_end` pulses with `rx_pkt_err` = 1, then IDLE.
- **Abort.** Pulses `rx_pkt_end` with `rx_pkt_err` = 1, then IDLE.
- **Bus reset.**
  - An 8-bit saturating counter counts synchronised SE0 cycles and clears on any non-SE0 cycle.
  - `usb_reset` is 1 while the count ≥ `RESET_CYCLES`.
  - If bus reset asserts while `rx_active`, the packet ends as an abort in that cycle.
- **Reset.** All outputs are 0, the FSM is in IDLE, and the previous sample is initialised to J.

## Timing
- Pin edge to synchronised state: 2 cycles.
- Synchronised edge to sample point: 1 cycle.
- Sample to decoded bit: 1 cycle, registered.
- `rx_pkt_start` is asserted 1 cycle after the sample of the final SYNC K.
- `rx_data_valid` is asserted 1 cycle after the sample of a byte's 8th data bit.
- `rx_data` is held until the next valid.
- `rx_pkt_end` is asserted 1 cycle after the J sample that ends the EOP.
- `rx_pkt_start`, `rx_data_valid` and `rx_pkt_end` never overlap. At most one pulse occurs per 4 cycles.
- Tolerance: edges may arrive 3..5 cycles apart without bit error, since each transition re-phases recovery.
- No backpressure: consumers must accept every pulse.

## Test plan
- **Clean packet.** Idle J, then SYNC + 0xA5 + 0x3C + SE0,SE0,J at 4 cycles/bit. Required: one `rx_pkt_start`; two `rx_data_valid` pulses with 0xA5 then 0x3C, ≥32 cycles apart; `rx_pkt_end` with `rx_pkt_err` = 0; `rx_active` covering start..end.
- **Bit stuffing.** Packet 0xFF, 0xFF with a stuffed 0 after every six 1s. Required: 0xFF, 0xFF and `rx_pkt_err` = 0. Same packet with one stuff bit replaced by 1: no second byte, `rx_pkt_end` with `rx_pkt_err` = 1.
- **Jitter.** 0xA5 with bit widths alternating 3 and 5 cycles. Required: 0xA5 received, no error.
- **Truncated packet.** SYNC, 10 data bits, EOP. Required: one byte valid, `rx_pkt_end` with `rx_pkt_err` = 1.
- **Bus reset.** SE0 held 200 cycles. Required: `usb_reset` rises exactly `RESET_CYCLES` cycles after synchronised SE0 begins and falls 1 cycle after synchronised J. SE0 held 100 cycles: `usb_reset` never asserts.
- **Async reset mid-byte.** `reset` = 0 mid-byte. Required: all outputs 0 immediately. After release, the next clean packet is received correctly.

Source files
------------

// File: rtl/usb_fs_rx_phy.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | usb_fs_rx_phy : full-speed USB receive front end (sync, clock        |
// | recovery, NRZI, unstuffing, SYNC/EOP, byte assembly, bus reset)      |
// | Rev 1.0                                                              |
// +---------------------------------------------------------------------+
module usb_fs_rx_phy #(
  parameter int RESET_CYCLES = 120,
  parameter int EOP_MAX_SE0  = 3
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       usb_p_rx,
  input  logic       usb_n_rx,
  output logic [1:0] line_state,
  output logic       rx_active,
  output logic       rx_pkt_start,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  output logic       rx_pkt_end,
  output logic       rx_pkt_err,
  output logic       usb_reset
);

  localparam logic [1:0] LS_SE0 = 2'd0;
  localparam logic [1:0] LS_J   = 2'd1;
  localparam logic [1:0] LS_K   = 2'd2;
  localparam logic [1:0] LS_SE1 = 2'd3;
  localparam logic [7:0] RST_LIM = RESET_CYCLES[7:0];
  localparam logic [3:0] EOP_MAX = EOP_MAX_SE0[3:0];

  typedef enum logic [1:0] {IDLE, DATA, EOP, ERR} state_t;

  logic [1:0] meta;
  logic [1:0] eff;
  logic [1:0] eff_prev;
  logic       change;
  logic [1:0] phase;
  logic       sample_en;
  logic [1:0] prev_jk;
  logic [5:0] hist;
  logic       dbit;
  logic       sync_done;
  state_t     state;
  logic [2:0] ones;
  logic [2:0] bit_cnt;
  logic       got_byte;
  logic [6:0] shreg;
  logic [3:0] eop_se0;
  logic       err_se0;
  logic [7:0] se0_cnt;
  logic       reset_rise;

  // Line state code is {D-, D+}, so J=1, K=2, SE0=0, SE1=3 fall out directly.
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      meta       <= 2'b00;
      line_state <= LS_SE0;
    end else begin
      meta       <= {usb_n_rx, usb_p_rx};
      line_state <= meta;
    end
  end

  assign eff       = (line_state == LS_SE1) ? eff_prev : line_state;
  assign change    = (eff != eff_prev);
  assign sample_en = (phase == 2'd1) && !change;
  assign dbit      = (eff == prev_jk);
  assign sync_done = (hist == {LS_K, LS_J, LS_K}) && (eff == LS_K);

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      se0_cnt <= 8'd0;
    end else if (line_state != LS_SE0) begin
      se0_cnt <= 8'd0;
    end else if (se0_cnt != 8'hFF) begin
      se0_cnt <= se0_cnt + 8'd1;
    end
  end

  assign usb_reset  = (se0_cnt >= RST_LIM);
  assign reset_rise = (line_state == LS_SE0) && (se0_cnt == RST_LIM - 8'd1);

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      eff_prev      <= LS_SE0;
      phase         <= 2'd0;
      prev_jk       <= LS_J;
      hist          <= {LS_J, LS_J, LS_J};
      state         <= IDLE;
      ones          <= 3'd0;
      bit_cnt       <= 3'd0;
      got_byte      <= 1'b0;
      shreg         <= 7'd0;
      eop_se0       <= 4'd0;
      err_se0       <= 1'b0;
      rx_active     <= 1'b0;
      rx_pkt_start  <= 1'b0;
      rx_data       <= 8'd0;
      rx_data_valid <= 1'b0;
      rx_pkt_end    <= 1'b0;
      rx_pkt_err    <= 1'b0;
    end else begin
      rx_pkt_start  <= 1'b0;
      rx_data_valid <= 1'b0;
      rx_pkt_end    <= 1'b0;
      rx_pkt_err    <= 1'b0;
      if (rx_pkt_end) rx_active <= 1'b0;

      // A transition counts as phase 0, so the sample lands on the next cycle.
      eff_prev <= eff;
      phase    <= change ? 2'd1 : phase + 2'd1;

      if (sample_en) begin
        hist <= {hist[3:0], eff};
        if (eff == LS_J || eff == LS_K) prev_jk <= eff;
      end

      if (reset_rise && state != IDLE) begin
        rx_pkt_end <= 1'b1;
        rx_pkt_err <= 1'b1;
        state      <= IDLE;
      end else if (sample_en) begin
        case (state)
          IDLE: begin
            if (sync_done) begin
              state        <= DATA;
              rx_pkt_start <= 1'b1;
              rx_active    <= 1'b1;
              ones         <= 3'd0;
              bit_cnt      <= 3'd0;
              got_byte     <= 1'b0;
            end
          end
          DATA: begin
            if (eff == LS_SE0) begin
              state   <= EOP;
              eop_se0 <= 4'd1;
            end else if (ones == 3'd6) begin
              if (dbit) begin
                state   <= ERR;
                err_se0 <= 1'b0;
              end else begin
                ones <= 3'd0;
              end
            end else begin
              ones    <= dbit ? ones + 3'd1 : 3'd0;
              shreg   <= {dbit, shreg[6:1]};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data       <= {dbit, shreg};
                rx_data_valid <= 1'b1;
                got_byte      <= 1'b1;
              end
            end
          end
          EOP: begin
            if (eff == LS_J) begin
              rx_pkt_end <= 1'b1;
              rx_pkt_err <= (bit_cnt != 3'd0) || !got_byte;
              state      <= IDLE;
            end else if (eff == LS_K || eop_se0 >= EOP_MAX) begin
              rx_pkt_end <= 1'b1;
              rx_pkt_err <= 1'b1;
              state      <= IDLE;
            end else begin
              eop_se0 <= eop_se0 + 4'd1;
            end
          end
          ERR: begin
            if (eff == LS_SE0) begin
              err_se0 <= 1'b1;
            end else if (eff == LS_J && err_se0) begin
              rx_pkt_end <= 1'b1;
              rx_pkt_err <= 1'b1;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_rx_phy.sv
`timescale 1ns/1ps
`default_nettype none
// tb_usb_fs_rx_phy : scoreboard bench; line symbols are built from byte lists,
// expected bytes and end-status are queued and matched against DUT pulses.
module tb_usb_fs_rx_phy;

  localparam int RESET_CYCLES = 120;
  localparam int EOP_MAX_SE0  = 3;
  localparam logic [1:0] SE0 = 2'd0;
  localparam logic [1:0] J   = 2'd1;
  localparam logic [1:0] K   = 2'd2;

  logic       clk_48mhz = 1'b0;
  logic       reset     = 1'b0;
  logic       usb_p_rx  = 1'b1;
  logic       usb_n_rx  = 1'b0;
  logic [1:0] line_state;
  logic       rx_active;
  logic       rx_pkt_start;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_pkt_end;
  logic       rx_pkt_err;
  logic       usb_reset;
  logic [15:0] all_outs;

  assign all_outs = {line_state, rx_active, rx_pkt_start, rx_data,
                     rx_data_valid, rx_pkt_end, rx_pkt_err, usb_reset};

  always #10 clk_48mhz = ~clk_48mhz;

  usb_fs_rx_phy #(
    .RESET_CYCLES (RESET_CYCLES),
    .EOP_MAX_SE0  (EOP_MAX_SE0)
  ) dut (
    .clk_48mhz     (clk_48mhz),
    .reset         (reset),
    .usb_p_rx      (usb_p_rx),
    .usb_n_rx      (usb_n_rx),
    .line_state    (line_state),
    .rx_active     (rx_active),
    .rx_pkt_start  (rx_pkt_start),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .rx_pkt_end    (rx_pkt_end),
    .rx_pkt_err    (rx_pkt_err),
    .usb_reset     (usb_reset)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         starts = 0;
  logic [7:0] exp_bytes[$];
  logic       exp_errs[$];
  int         valid_cyc[$];
  logic       data_bits[$];
  bit         chk_inactive = 1'b0;
  bit         jitter = 1'b0;
  bit         jtog   = 1'b0;
  logic [1:0] nrzi_lvl = J;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every DUT pulse is matched against the queues.
  always @(negedge clk_48mhz) begin
    cyc++;
    if (!reset) begin
      chk_inactive = 1'b0;
    end else begin
      if (chk_inactive) begin
        check_eq("active_after_end", 32'(rx_active), 32'd0);
        chk_inactive = 1'b0;
      end
      if (32'(rx_pkt_start) + 32'(rx_data_valid) + 32'(rx_pkt_end) > 32'd1)
        check_eq("pulse_overlap", 32'(rx_pkt_start) + 32'(rx_data_valid) + 32'(rx_pkt_end), 32'd1);
      if (rx_pkt_start) begin
        starts++;
        check_eq("active_at_start", 32'(rx_active), 32'd1);
      end
      if (rx_data_valid) begin
        check_eq("active_at_byte", 32'(rx_active), 32'd1);
        valid_cyc.push_back(cyc);
        if (exp_bytes.size() == 0) check_eq("unexpected_byte", 32'(rx_data_valid), 32'd0);
        else check_eq("rx_data", 32'(rx_data), 32'(exp_bytes.pop_front()));
      end
      if (rx_pkt_end) begin
        check_eq("active_at_end", 32'(rx_active), 32'd1);
        if (exp_errs.size() == 0) check_eq("unexpected_end", 32'(rx_pkt_end), 32'd0);
        else check_eq("rx_pkt_err", 32'(rx_pkt_err), 32'(exp_errs.pop_front()));
        chk_inactive = 1'b1;
      end
    end
  end

  task automatic drive(input logic [1:0] st, input int w);
    usb_p_rx = st[0];
    usb_n_rx = st[1];
    repeat (w) @(negedge clk_48mhz);
  endtask

  task automatic drive_bit(input logic [1:0] st);
    int w;
    w = jitter ? (jtog ? 5 : 3) : 4;
    jtog = ~jtog;
    drive(st, w);
  endtask

  task automatic send_nrzi(input logic b);
    if (!b) nrzi_lvl = (nrzi_lvl == J) ? K : J;
    drive_bit(nrzi_lvl);
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) data_bits.push_back(b[i]);
  endtask

  // bad_stuff selects which stuff bit (0-based) is sent as 1; n_se0 = 0 means no EOP.
  task automatic send_packet(input int bad_stuff, input int n_se0);
    int ones;
    int nstuff;
    ones = 0;
    nstuff = 0;
    for (int i = 0; i < 8; i++) drive_bit((i % 2 == 0 || i == 7) ? K : J);
    nrzi_lvl = K;
    foreach (data_bits[i]) begin
      send_nrzi(data_bits[i]);
      ones = data_bits[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_nrzi(nstuff == bad_stuff);
        nstuff++;
        ones = 0;
      end
    end
    if (n_se0 > 0) begin
      for (int i = 0; i < n_se0; i++) drive_bit(SE0);
      drive_bit(J);
      drive(J, 8);
    end
    data_bits.delete();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_errs.size() != 0 && n < 100) begin
      @(negedge clk_48mhz);
      n++;
    end
    check_eq("drain", 32'(exp_errs.size()), 32'd0);
  endtask

  task automatic run_packet(input int bad_stuff, input int n_se0);
    int s0;
    s0 = starts;
    send_packet(bad_stuff, n_se0);
    wait_drain();
    check_eq("pkt_start_count", 32'(starts - s0), 32'd1);
  endtask

  initial begin
    int  s0;
    int  rose;
    int  fell;
    bit  seen;

    repeat (3) @(negedge clk_48mhz);
    check_eq("reset_outputs", 32'(all_outs), 32'd0);
    reset = 1'b1;
    drive(J, 10);
    check_eq("line_state_idle", 32'(line_state), 32'(J));

    // Clean two-byte packet
    valid_cyc.delete();
    add_byte(8'hA5); add_byte(8'h3C);
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C); exp_errs.push_back(1'b0);
    run_packet(-1, 2);
    check_eq("byte_gap_ge_32",
             32'(valid_cyc.size() == 2 && (valid_cyc[1] - valid_cyc[0]) >= 32), 32'd1);

    // Bit stuffing, clean
    add_byte(8'hFF); add_byte(8'hFF);
    exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hFF); exp_errs.push_back(1'b0);
    run_packet(-1, 2);

    // Bit stuffing, second stuff bit violated
    add_byte(8'hFF); add_byte(8'hFF);
    exp_bytes.push_back(8'hFF); exp_errs.push_back(1'b1);
    run_packet(1, 2);

    // Jitter: alternating 3/5-cycle bits
    jitter = 1'b1; jtog = 1'b0;
    add_byte(8'hA5);
    exp_bytes.push_back(8'hA5); exp_errs.push_back(1'b0);
    run_packet(-1, 2);
    jitter = 1'b0;

    // Truncated: 10 data bits
    add_byte(8'hA5); data_bits.push_back(1'b1); data_bits.push_back(1'b0);
    exp_bytes.push_back(8'hA5); exp_errs.push_back(1'b1);
    run_packet(-1, 2);

    // EOP with the maximum tolerated SE0 length is still good
    add_byte(8'h5A);
    exp_bytes.push_back(8'h5A); exp_errs.push_back(1'b0);
    run_packet(-1, EOP_MAX_SE0);

    // One SE0 sample too many aborts
    add_byte(8'hC3);
    exp_bytes.push_back(8'hC3); exp_errs.push_back(1'b1);
    run_packet(-1, EOP_MAX_SE0 + 1);

    // Bus reset: 200 cycles of SE0
    rose = -1;
    usb_p_rx = 1'b0; usb_n_rx = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk_48mhz);
      if (usb_reset && rose < 0) rose = i;
    end
    check_eq("usb_reset_rise", 32'(rose), 32'(RESET_CYCLES + 2));
    fell = -1;
    usb_p_rx = 1'b1; usb_n_rx = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk_48mhz);
      if (!usb_reset && fell < 0) fell = i;
    end
    check_eq("usb_reset_fall", 32'(fell), 32'd3);

    // Short SE0: no bus reset
    seen = 1'b0;
    usb_p_rx = 1'b0; usb_n_rx = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_48mhz);
      if (usb_reset) seen = 1'b1;
    end
    usb_p_rx = 1'b1; usb_n_rx = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_48mhz);
      if (usb_reset) seen = 1'b1;
    end
    check_eq("usb_reset_short", 32'(seen), 32'd0);

    // Asynchronous reset in the middle of a byte
    s0 = starts;
    data_bits.push_back(1'b1); data_bits.push_back(1'b0);
    data_bits.push_back(1'b1); data_bits.push_back(1'b0);
    send_packet(-1, 0);
    check_eq("partial_start", 32'(starts - s0), 32'd1);
    check_eq("active_mid_packet", 32'(rx_active), 32'd1);
    #3 reset = 1'b0;
    #1 check_eq("async_reset_outputs", 32'(all_outs), 32'd0);
    usb_p_rx = 1'b1; usb_n_rx = 1'b0;
    repeat (3) @(negedge clk_48mhz);
    reset = 1'b1;
    drive(J, 10);

    add_byte(8'hA5); add_byte(8'h3C);
    exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C); exp_errs.push_back(1'b0);
    run_packet(-1, 2);

    check_eq("bytes_left", 32'(exp_bytes.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
